// File: rtl/pc_stack.sv
// pc_stack: parametrised program counter with a hardware return-address stack.
// One action per edge, priority clear > load > call > ret > inc > hold.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_CALL,
    ACT_RET,
    ACT_INC
  } act_t;

  act_t             act;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [DW-1:0]    depth_reg, depth_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             push_en, pop_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  assign empty     = (depth_reg == '0);
  assign full      = (depth_reg == DEPTH_W);
  assign out       = out_reg;
  assign depth     = depth_reg;
  assign overflow  = ovf_reg;
  assign underflow = unf_reg;
  assign wr_addr   = AW'(depth_reg);
  assign rd_addr   = AW'(depth_reg - DW'(1));

  always_comb begin
    act = ACT_HOLD;
    if (clear)     act = ACT_CLEAR;
    else if (load) act = ACT_LOAD;
    else if (call) act = ACT_CALL;
    else if (ret)  act = ACT_RET;
    else if (inc)  act = ACT_INC;
  end

  always_comb begin
    out_next   = out_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push_en    = 1'b0;
    pop_en     = 1'b0;
    case (act)
      ACT_CLEAR: begin
        out_next   = '0;
        depth_next = '0;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
      end
      ACT_LOAD: out_next = in;
      ACT_CALL: begin
        // The jump happens even when the push has to be dropped.
        out_next = in;
        if (full) begin
          ovf_next = 1'b1;
        end else begin
          push_en    = 1'b1;
          depth_next = depth_reg + DW'(1);
        end
      end
      ACT_RET: begin
        if (empty) begin
          unf_next = 1'b1;
        end else begin
          pop_en     = 1'b1;
          depth_next = depth_reg - DW'(1);
        end
      end
      ACT_INC: out_next = out_reg + STEP_W;
      default: ;
    endcase
  end

  // A pop reads the stack straight into the PC register (registered read).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg   <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      if (pop_en) out_reg <= stack_mem[rd_addr];
      else        out_reg <= out_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack contents are not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (push_en && reset_n) stack_mem[wr_addr] <= out_reg + STEP_W;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack: directed vector table, async-reset sequence and
// randomized commands checked against a queue-based reference model.
module tb_pc_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [WIDTH-1:0] in = '0;
  logic             clear = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .in(in),
    .clear(clear), .load(load), .inc(inc), .call(call), .ret(ret),
    .out(out), .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        c, l, i, ca, r;
    logic [15:0] din;
    logic [15:0] e_out;
    int          e_depth;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int unsigned m_pc;
  int unsigned m_q[$];
  logic        m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_out, input int e_depth,
                           input logic e_ovf, input logic e_unf);
    check({tag, ".out"},       32'(out),       32'(e_out));
    check({tag, ".depth"},     32'(depth),     32'(e_depth));
    check({tag, ".empty"},     32'(empty),     32'(e_depth == 0));
    check({tag, ".full"},      32'(full),      32'(e_depth == DEPTH));
    check({tag, ".overflow"},  32'(overflow),  32'(e_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(e_unf));
  endtask

  task automatic drive(input logic c, input logic l, input logic i, input logic ca,
                       input logic r, input logic [15:0] d);
    clear = c; load = l; inc = i; call = ca; ret = r; in = d;
    @(posedge clk);
    #1;
    clear = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic add(input logic c, input logic l, input logic i, input logic ca, input logic r,
                     input logic [15:0] d, input logic [15:0] eo, input int ed,
                     input logic eov, input logic eun);
    vec_t v;
    v.c = c; v.l = l; v.i = i; v.ca = ca; v.r = r; v.din = d;
    v.e_out = eo; v.e_depth = ed; v.e_ovf = eov; v.e_unf = eun;
    vecs.push_back(v);
  endtask

  task automatic model_step(input logic c, input logic l, input logic i, input logic ca,
                            input logic r, input int unsigned d);
    if (c) begin
      m_pc = 0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (l) begin
      m_pc = d;
    end else if (ca) begin
      if (m_q.size() < DEPTH) m_q.push_back((m_pc + 1) % 65536);
      else m_ovf = 1'b1;
      m_pc = d;
    end else if (r) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else m_unf = 1'b1;
    end else if (i) begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  initial begin
    // Directed vectors, starting from the post-reset state (out=0, empty).
    add(0,0,1,0,0, 16'd0,     16'd1,     0, 0, 0);
    add(0,0,1,0,0, 16'd0,     16'd2,     0, 0, 0);
    add(0,1,1,0,0, 16'h8285,  16'h8285,  0, 0, 0);
    add(0,0,1,0,0, 16'd0,     16'h8286,  0, 0, 0);
    add(0,0,1,0,0, 16'd0,     16'h8287,  0, 0, 0);
    add(1,1,0,0,0, 16'd12345, 16'd0,     0, 0, 0);
    add(1,0,1,0,0, 16'd0,     16'd0,     0, 0, 0);
    add(0,1,0,0,0, 16'd100,   16'd100,   0, 0, 0);
    add(0,0,0,1,0, 16'd500,   16'd500,   1, 0, 0);
    add(0,0,0,1,0, 16'd900,   16'd900,   2, 0, 0);
    add(0,0,0,0,1, 16'd0,     16'd501,   1, 0, 0);
    add(0,0,0,0,1, 16'd0,     16'd101,   0, 0, 0);
    // Nine calls from out=101: pushes 102, then 1001, 1011, ..., 1061; ninth dropped.
    for (int k = 0; k < 9; k++)
      add(0,0,0,1,0, 16'(1000 + 10*k), 16'(1000 + 10*k), (k < 8) ? k + 1 : 8, k == 8, 0);
    for (int m = 7; m >= 0; m--)
      add(0,0,0,0,1, 16'd0, (m == 0) ? 16'd102 : 16'(1000 + 10*(m-1) + 1), m, 1, 0);
    add(0,0,0,0,1, 16'd0,     16'd102,   0, 1, 1);
    add(0,1,0,0,0, 16'hFFFF,  16'hFFFF,  0, 1, 1);
    add(0,0,1,0,0, 16'd0,     16'h0000,  0, 1, 1);
    add(0,0,0,1,1, 16'h0040,  16'h0040,  1, 1, 1);
    add(0,1,0,1,0, 16'd7,     16'd7,     1, 1, 1);
    add(0,0,0,0,1, 16'd0,     16'd1,     0, 1, 1);
    add(1,0,0,0,0, 16'd0,     16'd0,     0, 0, 0);

    // Async reset asserted between edges, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1 check_all("reset_async", 16'd0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_all("reset_release", 16'd0, 0, 0, 0);

    foreach (vecs[n]) begin
      drive(vecs[n].c, vecs[n].l, vecs[n].i, vecs[n].ca, vecs[n].r, vecs[n].din);
      $display("vec %0d clr=%0b ld=%0b inc=%0b call=%0b ret=%0b in=%h -> out=%h depth=%0d ovf=%0b unf=%0b",
               n, vecs[n].c, vecs[n].l, vecs[n].i, vecs[n].ca, vecs[n].r, vecs[n].din,
               out, depth, overflow, underflow);
      check_all($sformatf("vec%0d", n), vecs[n].e_out, vecs[n].e_depth, vecs[n].e_ovf, vecs[n].e_unf);
    end

    // Build depth=3 with overflow set, then reset between edges.
    for (int k = 0; k < 9; k++) drive(0,0,0,1,0, 16'(200 + k));
    for (int k = 0; k < 5; k++) drive(0,0,0,0,1, 16'd0);
    check("pre_reset.depth",    32'(depth),    32'd3);
    check("pre_reset.overflow", 32'(overflow), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_all("mid_reset", 16'd0, 0, 0, 0);
    call = 1'b1; in = 16'h1234;
    @(posedge clk); #1;
    check_all("held_reset", 16'd0, 0, 0, 0);
    call = 1'b0;
    reset_n = 1'b1;
    drive(0,0,0,0,0, 16'd0);
    check_all("after_reset", 16'd0, 0, 0, 0);
    $display("async reset sequence: out=%h depth=%0d", out, depth);

    // Randomized phase against the reference model.
    m_pc = 0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    for (int t = 0; t < 600; t++) begin
      logic c, l, i, ca, r;
      logic [15:0] d;
      c  = ($urandom_range(59) == 0);
      l  = ($urandom_range(7) == 0);
      i  = ($urandom_range(1) == 0);
      ca = ($urandom_range(2) == 0);
      r  = ($urandom_range(2) == 0);
      d  = 16'($urandom);
      drive(c, l, i, ca, r, d);
      model_step(c, l, i, ca, r, 32'(d));
      $display("rnd %0d clr=%0b ld=%0b inc=%0b call=%0b ret=%0b in=%h -> out=%h depth=%0d ovf=%0b unf=%0b",
               t, c, l, i, ca, r, d, out, depth, overflow, underflow);
      check_all($sformatf("rnd%0d", t), 16'(m_pc), m_q.size(), m_ovf, m_unf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the CPU datapath: next generation of the 16-bit reset/load/inc PC.
- Width and increment step are generic.
- Adds a hardware return-address stack (call/ret) with depth tracking and sticky overflow/underflow flags.
- Sits between the control unit (jump/call/ret decode) and instruction memory address input.

Parameters:
- WIDTH, 16, counter and address width in bits.
- DEPTH, 8, return-stack entries (>=1).
- STEP, 1, increment applied by inc and used for the call return address.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  jump/load/call target.
- clear  input  1  synchronous clear (legacy PC reset function).
- load  input  1  load in into PC.
- inc  input  1  advance PC by STEP.
- call  input  1  push return address, jump to in.
- ret  input  1  pop stack into PC.
- out  output  WIDTH  current PC (registered).
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- empty  output  1  depth==0 (combinational from depth).
- full  output  1  depth==DEPTH (combinational from depth).
- overflow  output  1  sticky: call attempted while full.
- underflow  output  1  sticky: ret attempted while empty.

Behaviour:
- Async reset (reset_n=0): immediately out=0, depth=0, overflow=0, underflow=0; empty=1, full=0. Stack RAM contents not reset. Deassertion is sampled by the first rising edge with reset_n=1.
- All other updates occur on the rising clk edge. out changes visibly one edge after the command is sampled.
- Priority per edge (exactly one action): clear > load > call > ret > inc > hold.
- clear: out<=0, depth<=0, overflow<=0, underflow<=0.
- load: out<=in. Stack and flags unchanged.
- call, not full: stack[depth]<=out+STEP (mod 2^WIDTH), depth<=depth+1, out<=in.
- call, full: out<=in, push dropped, depth unchanged, overflow<=1.
- ret, not empty: out<=stack[depth-1], depth<=depth-1.
- ret, empty: out holds, underflow<=1.
- inc: out<=out+STEP mod 2^WIDTH. Wrap-around is silent; no flag.
- call+ret together: call wins, ret ignored. load with call/ret: load wins, no push/pop.
- Arithmetic is unsigned modulo 2^WIDTH. Negative test values are their two's-complement bit patterns.
- Sticky flags are cleared only by reset_n or clear.
- Reset mid-call/ret: no partial update; the async reset values win.

Test Plan:
- reset_n=0 then release, all commands 0 -> out=0, depth=0, empty=1, flags=0. Then inc for 2 edges -> out=1, then 2.
- Load and inc: load in=0x8285 (-32123) with inc=1 -> out=0x8285. Then inc for 2 edges -> 0x8286, 0x8287. Then load 12345 with clear=1 -> out=0. Then inc=1 with clear=1 -> out stays 0.
- Nested call/ret: out=100, call in=500 -> out=500, depth=1. Call in=900 -> out=900, depth=2. Ret -> out=501, depth=1. Ret -> out=101, depth=0.
- Overflow (DEPTH=8): 9 consecutive calls -> depth=8, full=1, overflow=1, out=last target. Then 8 rets return the first 8 return addresses in reverse order. A 9th ret -> out holds, underflow=1.
- Wrap and priority: out=0xFFFF, inc -> 0x0000. Call+ret together, in=0x0040 -> out=0x0040, depth+1. Load+call, in=7 -> out=7, depth unchanged.
- Async reset mid-operation: assert reset_n=0 between edges while depth=3, overflow=1 -> out, depth and flags go to 0 immediately without a clock edge.
